axi_wbeat_joiner: RTL



---
 rtl/axi_wbeat_joiner.sv | 101 ++++++++++
 1 files changed

// File: rtl/axi_wbeat_joiner.sv
// ============================================================================
//  Module      : axi_wbeat_joiner
//  Description : Pairs per-beat addresses with AXI4 W beats, issues registered
//                word writes and queues B responses for completed bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_wbeat_joiner #(
    parameter int ADDR_WIDTH    = 12,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_PENDING_B = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     i_addr_data,
    input  logic                      i_addr_valid,
    output logic                      i_addr_ready,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_wstrb,
    input  logic                      i_wlast,
    input  logic                      i_wvalid,
    output logic                      i_wready,
    output logic [1:0]                o_bresp,
    output logic                      o_bvalid,
    input  logic                      i_bready,
    output logic                      o_mem_we,
    output logic [ADDR_WIDTH-3:0]     o_mem_addr,
    output logic [DATA_WIDTH-1:0]     o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_mem_wstrb
);

    localparam logic [3:0] c_max_pending = 4'(MAX_PENDING_B);
    localparam logic [1:0] c_resp_okay   = 2'b00;

    logic [3:0]              r_pending_b;
    logic                    r_mem_we;
    logic [ADDR_WIDTH-3:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;
    logic [DATA_WIDTH/8-1:0] r_mem_wstrb;

    logic w_can_accept;
    logic w_fire;
    logic w_inc;
    logic w_dec;

    // Admission is gated on queue space for every beat, not only WLAST beats,
    // so the full check never needs to look at i_wlast.
    assign w_can_accept = (r_pending_b < c_max_pending);
    assign w_fire       = i_addr_valid && i_wvalid && w_can_accept;
    assign i_wready     = i_addr_valid && w_can_accept;
    assign i_addr_ready = i_wvalid && w_can_accept;

    assign w_inc = w_fire && i_wlast;
    assign w_dec = o_bvalid && i_bready;

    assign o_bvalid    = (r_pending_b != 4'd0);
    assign o_bresp     = c_resp_okay;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_wstrb = r_mem_wstrb;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending_b <= 4'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            r_mem_we <= w_fire;
            if (w_fire) begin
                r_mem_addr  <= i_addr_data[ADDR_WIDTH-1:2];
                r_mem_wdata <= i_wdata;
                r_mem_wstrb <= i_wstrb;
            end
            if (w_inc && !w_dec) begin
                r_pending_b <= r_pending_b + 4'd1;
            end else if (w_dec && !w_inc) begin
                r_pending_b <= r_pending_b - 4'd1;
            end
        end
    end

`ifndef SYNTHESIS
    a_addr_aligned : assert property (@(posedge clk) disable iff (reset)
        i_addr_valid |-> (i_addr_data[1:0] == 2'b00));
    a_pending_bound : assert property (@(posedge clk) disable iff (reset)
        r_pending_b <= c_max_pending);
    a_no_fire_full : assert property (@(posedge clk) disable iff (reset)
        !w_can_accept |-> !w_fire);
    a_we_after_fire : assert property (@(posedge clk) disable iff (reset)
        r_mem_we |-> $past(w_fire));
    a_bvalid_stable : assert property (@(posedge clk) disable iff (reset)
        (o_bvalid && !i_bready) |=> o_bvalid);
`endif

endmodule

`default_nettype wire
